// File: rtl/image_mem_ctrl.sv
// Image memory controller: fills the 28x28 frame from the capture stream, streams it
// to the classifier and shares the single read port with the VGA display reader.
module image_mem_ctrl #(
    parameter int NPIX = 784,
    parameter int AW   = 10,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_start,
    input  logic          cap_valid,
    input  logic [DW-1:0] cap_data,
    output logic          cap_ready,
    input  logic          nn_start,
    output logic          nn_pix_valid,
    output logic [DW-1:0] nn_pix_data,
    output logic [AW-1:0] nn_pix_idx,
    input  logic          nn_pix_ready,
    output logic          nn_done,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_gnt,
    output logic          disp_valid,
    output logic [DW-1:0] disp_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          frame_ready,
    output logic          busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_READY,
        S_STREAM
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [AW:0]   NPIX_EXT  = (AW+1)'(NPIX);

    state_t        state_q, state_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [AW:0]   rcnt_q, rcnt_d;
    logic          nn_pend_q, nn_pend_d;
    logic          nn_pix_valid_q, nn_pix_valid_d;
    logic [DW-1:0] nn_pix_data_q, nn_pix_data_d;
    logic [AW-1:0] nn_pix_idx_q, nn_pix_idx_d;
    logic          nn_done_q, nn_done_d;
    logic          disp_valid_q, disp_valid_d;
    logic          disp_oob_q, disp_oob_d;
    logic [AW-1:0] mem_raddr_q, mem_raddr_d;
    logic          prio_disp_q, prio_disp_d;

    logic          nn_accept;
    logic          stream_want;
    logic          stream_gnt;
    logic          disp_oob;
    logic [AW-1:0] cap_addr;

    always_comb begin
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        rcnt_d         = rcnt_q;
        nn_pend_d      = 1'b0;
        nn_pix_valid_d = nn_pix_valid_q;
        nn_pix_data_d  = nn_pix_data_q;
        nn_pix_idx_d   = nn_pix_idx_q;
        nn_done_d      = 1'b0;
        disp_valid_d   = 1'b0;
        disp_oob_d     = 1'b0;
        mem_raddr_d    = mem_raddr_q;
        prio_disp_d    = prio_disp_q;
        cap_ready      = 1'b0;
        mem_we         = 1'b0;
        mem_waddr      = '0;
        mem_wdata      = '0;
        cap_addr       = cap_start ? '0 : wcnt_q;

        // The stream only asks for the port when it can take the returning pixel.
        nn_accept   = nn_pix_valid_q && nn_pix_ready;
        stream_want = (state_q == S_STREAM) && !nn_pend_q && (rcnt_q < NPIX_EXT)
                      && (!nn_pix_valid_q || nn_pix_ready);
        disp_oob    = ({1'b0, disp_addr} >= NPIX_EXT);
        disp_gnt    = disp_req && (!stream_want || prio_disp_q);
        stream_gnt  = stream_want && !disp_gnt;
        if (disp_req && stream_want) begin
            prio_disp_d = stream_gnt;
        end

        if (disp_gnt) begin
            disp_valid_d = 1'b1;
            disp_oob_d   = disp_oob;
            if (!disp_oob) begin
                mem_raddr_d = disp_addr;
            end
        end

        // mem_raddr_q still holds the stream address during the cycle its data returns.
        if (nn_accept) begin
            nn_pix_valid_d = 1'b0;
        end
        if (nn_pend_q) begin
            nn_pix_valid_d = 1'b1;
            nn_pix_data_d  = mem_rdata;
            nn_pix_idx_d   = mem_raddr_q;
        end
        if (stream_gnt) begin
            nn_pend_d   = 1'b1;
            mem_raddr_d = rcnt_q[AW-1:0];
            rcnt_d      = rcnt_q + (AW+1)'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cap_start) begin
                    state_d = S_CAPTURE;
                    wcnt_d  = '0;
                end
            end
            S_CAPTURE: begin
                cap_ready = 1'b1;
                if (cap_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = cap_addr;
                    mem_wdata = cap_data;
                    if (cap_addr == LAST_ADDR) begin
                        state_d = S_READY;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = cap_addr + AW'(1);
                    end
                end else if (cap_start) begin
                    wcnt_d = '0;
                end
            end
            S_READY: begin
                if (cap_start) begin
                    state_d = S_CAPTURE;
                    wcnt_d  = '0;
                end else if (nn_start) begin
                    state_d = S_STREAM;
                    rcnt_d  = '0;
                end
            end
            S_STREAM: begin
                if (nn_accept && (nn_pix_idx_q == LAST_ADDR)) begin
                    state_d   = S_READY;
                    nn_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wcnt_q         <= '0;
            rcnt_q         <= '0;
            nn_pend_q      <= 1'b0;
            nn_pix_valid_q <= 1'b0;
            nn_pix_data_q  <= '0;
            nn_pix_idx_q   <= '0;
            nn_done_q      <= 1'b0;
            disp_valid_q   <= 1'b0;
            disp_oob_q     <= 1'b0;
            mem_raddr_q    <= '0;
            prio_disp_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            rcnt_q         <= rcnt_d;
            nn_pend_q      <= nn_pend_d;
            nn_pix_valid_q <= nn_pix_valid_d;
            nn_pix_data_q  <= nn_pix_data_d;
            nn_pix_idx_q   <= nn_pix_idx_d;
            nn_done_q      <= nn_done_d;
            disp_valid_q   <= disp_valid_d;
            disp_oob_q     <= disp_oob_d;
            mem_raddr_q    <= mem_raddr_d;
            prio_disp_q    <= prio_disp_d;
        end
    end

    assign nn_pix_valid = nn_pix_valid_q;
    assign nn_pix_data  = nn_pix_data_q;
    assign nn_pix_idx   = nn_pix_idx_q;
    assign nn_done      = nn_done_q;
    assign disp_valid   = disp_valid_q;
    assign disp_data    = (disp_valid_q && !disp_oob_q) ? mem_rdata : '0;
    assign mem_raddr    = mem_raddr_q;
    assign frame_ready  = (state_q == S_READY) || (state_q == S_STREAM);
    assign busy         = (state_q == S_CAPTURE) || (state_q == S_STREAM);

endmodule

// File: tb/tb_image_mem_ctrl.sv
// Randomized bench for image_mem_ctrl: a frame-level reference image, an index
// scoreboard for the classifier stream and a negedge-clocked image memory.
module tb_image_mem_ctrl;
    localparam int NPIX = 784;
    localparam int AW   = 10;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cap_start = 1'b0;
    logic          cap_valid = 1'b0;
    logic [DW-1:0] cap_data = '0;
    logic          cap_ready;
    logic          nn_start = 1'b0;
    logic          nn_pix_valid;
    logic [DW-1:0] nn_pix_data;
    logic [AW-1:0] nn_pix_idx;
    logic          nn_pix_ready = 1'b0;
    logic          nn_done;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_gnt;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          frame_ready;
    logic          busy;

    image_mem_ctrl #(.NPIX(NPIX), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .cap_start(cap_start), .cap_valid(cap_valid), .cap_data(cap_data), .cap_ready(cap_ready),
        .nn_start(nn_start), .nn_pix_valid(nn_pix_valid), .nn_pix_data(nn_pix_data),
        .nn_pix_idx(nn_pix_idx), .nn_pix_ready(nn_pix_ready), .nn_done(nn_done),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .frame_ready(frame_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Image memory: read-before-write on the falling edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(negedge clk) begin
        mem_rdata <= mem[mem_raddr];
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    logic [DW-1:0] ref_img [0:(1<<AW)-1];
    int            n_vec = 0;
    int            n_err = 0;
    bit            disp_pend_exp = 1'b0;
    logic [DW-1:0] disp_exp = '0;
    bit            disp_hold = 1'b0;
    int            lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_disp();
        if (disp_pend_exp) begin
            chk("disp_valid", disp_valid, 1);
            chk("disp_data", disp_data, disp_exp);
        end else begin
            chk("disp_valid_quiet", disp_valid, 0);
        end
        disp_pend_exp = disp_req && disp_gnt;
        if (disp_pend_exp) disp_exp = (int'(disp_addr) >= NPIX) ? '0 : ref_img[disp_addr];
    endtask

    task automatic sample_edge();
        @(negedge clk);
        #1;
        check_disp();
    endtask

    task automatic drive_disp(input int dmode);
        if (dmode == 0) begin
            disp_req  = 1'b0;
            disp_addr = '0;
        end else if (dmode == 1) begin
            disp_req  = 1'b1;
            disp_addr = AW'(5);
        end else if (!disp_hold) begin
            disp_req  = ($urandom_range(1) == 1);
            disp_addr = AW'($urandom_range(850));
        end
    endtask

    task automatic do_reset();
        drive_edge();
        rst = 1'b1; cap_start = 0; cap_valid = 0; nn_start = 0; nn_pix_ready = 0; disp_req = 0;
        disp_pend_exp = 1'b0;
        disp_hold = 1'b0;
        repeat (2) drive_edge();
        drive_edge();
        rst = 1'b0;
        sample_edge();
        chk("rst_busy", busy, 0);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_cap_ready", cap_ready, 0);
        chk("rst_nn_valid", nn_pix_valid, 0);
        chk("rst_nn_idx", nn_pix_idx, 0);
        chk("rst_nn_data", nn_pix_data, 0);
        chk("rst_nn_done", nn_done, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_raddr", mem_raddr, 0);
    endtask

    task automatic oob_test();
        drive_edge();
        disp_req = 1'b1; disp_addr = AW'(800);
        sample_edge();
        chk("oob_gnt", disp_gnt, 1);
        drive_edge();
        disp_req = 1'b0;
        sample_edge();
        chk("oob_raddr_untouched", mem_raddr, 0);
    endtask

    task automatic run_capture(input int mode);
        int i = 0;
        int cyc = 0;
        logic [DW-1:0] d;
        drive_edge();
        cap_start = 1'b1; cap_valid = 1'b0; disp_req = 1'b0; disp_hold = 1'b0; nn_start = 1'b0;
        sample_edge();
        chk("cap_ready_before", cap_ready, 0);
        while (i < NPIX && cyc < 5000) begin
            drive_edge();
            cap_start = 1'b0;
            cap_valid = ($urandom_range(3) != 0);
            d = (mode == 0) ? DW'(i) : DW'($urandom);
            cap_data = cap_valid ? d : DW'($urandom);
            sample_edge();
            cyc++;
            chk("cap_ready", cap_ready, 1);
            chk("cap_busy", busy, 1);
            chk("cap_frame_ready_low", frame_ready, 0);
            chk("cap_mem_we", mem_we, cap_valid);
            if (cap_valid) begin
                chk("cap_waddr", mem_waddr, i);
                chk("cap_wdata", mem_wdata, d);
                ref_img[i] = d;
                i++;
            end
        end
        chk("capture_completed", i, NPIX);
        drive_edge();
        cap_valid = 1'b0;
        sample_edge();
        chk("cap_frame_ready", frame_ready, 1);
        chk("cap_ready_after", cap_ready, 0);
        chk("cap_busy_after", busy, 0);
        chk("cap_mem_we_after", mem_we, 0);
    endtask

    task automatic run_disp_idle(input int n);
        repeat (n) begin
            drive_edge();
            drive_disp(2);
            sample_edge();
            chk("disp_gnt_idle", disp_gnt, disp_req);
            disp_hold = 1'b0;
        end
        drive_edge();
        disp_req = 1'b0;
        sample_edge();
    endtask

    task automatic run_stream(input int rdy_pct, input int dmode, input int abort_at, output int cycles);
        int exp_idx = 0;
        int cyc = 0;
        int dgr = 0;
        int dden = 0;
        bit fin = 1'b0;
        bit prev_stall = 1'b0;
        bit denied_prev = 1'b0;
        bit abort_now = 1'b0;
        drive_edge();
        nn_start = 1'b1; disp_req = 1'b0; disp_hold = 1'b0;
        sample_edge();
        chk("stream_pre_frame_ready", frame_ready, 1);
        chk("stream_pre_busy", busy, 0);
        while (!fin && !abort_now && cyc < 20000) begin
            drive_edge();
            nn_start     = (exp_idx < NPIX) && ($urandom_range(15) == 0);
            cap_start    = (exp_idx < NPIX) && ($urandom_range(31) == 0);
            nn_pix_ready = (int'($urandom_range(99)) < rdy_pct);
            drive_disp(dmode);
            if (abort_at >= 0 && exp_idx >= abort_at) begin
                rst = 1'b1; abort_now = 1'b1; nn_start = 1'b0; cap_start = 1'b0; disp_req = 1'b0;
            end
            sample_edge();
            cyc++;
            chk("stream_frame_ready", frame_ready, 1);
            if (prev_stall) chk("stream_valid_held", nn_pix_valid, 1);
            if (nn_done) begin
                chk("done_after_last", exp_idx, NPIX);
                fin = 1'b1;
            end else begin
                chk("stream_busy", busy, 1);
                chk("stream_cap_ready", cap_ready, 0);
                if (nn_pix_valid) begin
                    chk("nn_pix_idx", nn_pix_idx, exp_idx);
                    chk("nn_pix_data", nn_pix_data, ref_img[exp_idx]);
                    if (nn_pix_ready) exp_idx++;
                end
            end
            prev_stall = nn_pix_valid && !nn_pix_ready;
            if (disp_req) begin
                if (disp_gnt) begin
                    dgr++;
                    denied_prev = 1'b0;
                end else begin
                    chk("disp_denied_twice", denied_prev, 0);
                    dden++;
                    denied_prev = 1'b1;
                end
            end
            disp_hold = disp_req && !disp_gnt;
        end
        cap_start = 1'b0;
        nn_start  = 1'b0;
        if (!abort_now) chk("stream_completed", fin, 1);
        cycles = cyc;
        if (dmode == 1) begin
            chk("disp_got_grants", dgr > 0, 1);
            chk("stream_won_port", dden > 0, 1);
        end
        if (fin) begin
            drive_edge();
            nn_pix_ready = 1'b0; disp_req = 1'b0; disp_hold = 1'b0;
            sample_edge();
            chk("done_single_pulse", nn_done, 0);
            chk("post_stream_frame_ready", frame_ready, 1);
            chk("post_stream_busy", busy, 0);
            chk("post_stream_valid", nn_pix_valid, 0);
        end
    endtask

    task automatic post_abort_checks();
        drive_edge();
        rst = 1'b0; nn_pix_ready = 1'b0; disp_req = 1'b0; disp_hold = 1'b0;
        sample_edge();
        chk("abort_busy", busy, 0);
        chk("abort_frame_ready", frame_ready, 0);
        chk("abort_nn_valid", nn_pix_valid, 0);
        chk("abort_nn_done", nn_done, 0);
        chk("abort_cap_ready", cap_ready, 0);
        drive_edge();
        nn_start = 1'b1;
        sample_edge();
        chk("idle_nn_start_busy", busy, 0);
        for (int k = 0; k < 10; k++) begin
            drive_edge();
            nn_start = 1'b0;
            sample_edge();
            chk("idle_busy", busy, 0);
            chk("idle_frame_ready", frame_ready, 0);
            chk("idle_nn_valid", nn_pix_valid, 0);
            chk("idle_nn_done", nn_done, 0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        oob_test();
        run_capture(0);
        run_disp_idle(24);
        run_stream(100, 0, -1, lat);
        chk("stream_latency_window", (lat >= 1560) && (lat <= 1580), 1);
        run_stream(100, 1, -1, lat);
        run_stream(50, 2, -1, lat);
        run_capture(1);
        run_stream(70, 2, 300, lat);
        post_abort_checks();
        run_capture(1);
        run_disp_idle(16);
        run_stream(60, 2, -1, lat);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/image_mem_ctrl.md
Name: image_mem_ctrl

Overview:
Sequences and shares the 28x28 8-bit grayscale image memory (784 entries, 10-bit address, single write port, single read port).
- Write port: fills the memory from a capture pixel stream.
- Read port: arbitrated between the VGA display reader and a pixel stream to the classifier.
- Frame status and a start/done handshake go to the top-level control.
Sits between the capture/downsample logic, the display path, the inference engine and the image memory.

Parameters:
NPIX, 784, pixels per frame (memory depth)
AW, 10, memory address width
DW, 8, pixel width

Ports:
clk  in  1  system clock; memory is also clocked by clk (negedge access)
rst  in  1  synchronous active-high reset
cap_start  in  1  pulse: begin capturing a new frame
cap_valid  in  1  capture pixel valid
cap_data  in  DW  capture pixel
cap_ready  out  1  controller accepts capture pixel
nn_start  in  1  pulse: stream stored frame to classifier
nn_pix_valid  out  1  classifier pixel valid
nn_pix_data  out  DW  classifier pixel
nn_pix_idx  out  AW  index (0..NPIX-1) of nn_pix_data
nn_pix_ready  in  1  classifier accepts pixel
nn_done  out  1  one-cycle pulse after last pixel accepted
disp_req  in  1  display read request
disp_addr  in  AW  display read address
disp_gnt  out  1  display request granted this cycle (combinational)
disp_valid  out  1  display read data valid
disp_data  out  DW  display read data
mem_we  out  1  memory write enable
mem_waddr  out  AW  memory write address
mem_wdata  out  DW  memory write data
mem_raddr  out  AW  memory read address
mem_rdata  in  DW  memory read data
frame_ready  out  1  complete frame stored
busy  out  1  state is CAPTURE or STREAM

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled on the rising edge.
- Reset state: IDLE. All outputs 0, all counters 0, no pending read. Memory contents are untouched. Reset mid-capture or mid-stream aborts immediately; nn_done is not pulsed.
- Memory timing: mem_raddr is driven from posedge registers. mem_rdata is valid at the next posedge, so read latency is 1 cycle. Writes take effect on the same negedge.
- States:
  - IDLE: cap_start -> CAPTURE.
  - CAPTURE: cap_ready=1. Each cycle with cap_valid writes mem_we=1, mem_waddr=wcnt, mem_wdata=cap_data, then wcnt++. The write with wcnt=NPIX-1 -> READY, frame_ready=1 the next cycle, wcnt=0. cap_start in CAPTURE restarts at wcnt=0.
  - READY: cap_start -> CAPTURE, frame_ready cleared. nn_start -> STREAM. If both arrive the same cycle, cap_start wins.
  - STREAM: streams addresses 0..NPIX-1 in order. cap_start and nn_start are ignored; cap_ready=0. Acceptance of idx NPIX-1 -> nn_done pulse the next cycle, return to READY; frame_ready stays 1.
- nn_start outside READY is ignored. cap_start in STREAM is ignored.
- Stream handshake:
  - At most one read outstanding. A read is issued when the stream is granted the port, there is no pending read, rcnt < NPIX, and the output register is empty or being accepted this cycle.
  - Returned data loads nn_pix_valid/data/idx one cycle after issue.
  - nn_pix_valid, nn_pix_data and nn_pix_idx hold stable while nn_pix_ready=0.
  - Peak throughput is 1 pixel per 2 cycles.
- Read-port arbitration (STREAM state only; in other states the display always wins):
  - If only one requester, it is granted.
  - If both request, priority alternates: the requester denied last contended cycle wins. Display wins the first contention after reset.
  - The denied display keeps disp_req/disp_addr asserted and stable until disp_gnt.
  - A granted display read gives disp_valid=1 and disp_data one cycle later.
- Display boundary: disp_addr >= NPIX is granted without a memory access; disp_valid=1 and disp_data=0 the next cycle.
- Display reads are permitted during CAPTURE and return current memory contents (partially updated frame). Same-cycle read and write to one address returns old data.
- busy = (state==CAPTURE or STREAM).

Test Plan:
- Reset, then cap_start and 784 cap_valid beats with data=idx[7:0] -> 784 writes at addresses 0..783; frame_ready=1 exactly one cycle after the last write; cap_ready=0 afterwards.
- nn_start with nn_pix_ready held high -> indices 0..783 in order, data matching memory; nn_done pulses once about 1568 cycles later; frame_ready stays 1.
- During STREAM, toggle nn_pix_ready randomly -> no pixel lost or duplicated; outputs stable while stalled; idx sequence strictly incremental.
- During STREAM, hold disp_req continuously at addr 5 -> grants alternate display/stream; disp_data=5 each grant; stream still completes.
- disp_addr=800 in IDLE -> disp_gnt=1, disp_valid=1 next cycle, disp_data=0, mem_raddr unchanged.
- Assert rst at pixel 300 of STREAM, then issue nn_start -> ignored (state IDLE, frame_ready=0); no nn_done; capture of a new frame works normally.
